pc_fetch_sequencer: RTL

The fetch sequencer owns the program counter of the single-cycle core and controls the instruction-fetch side of the datapath. Its FSM issues an instruction-memory request at the current PC and holds the returned word for the datapath until the datapath retires it. It then advances the PC by 4 or loads a redirect target (branch or jump), or stops on a halt. It supports a multi-cycle instruction memory, detects fetch timeouts and misaligned targets, and makes both conditions sticky until reset.

---
 rtl/pc_fetch_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer for the single-cycle core. It owns the PC, fetches from a variable-latency
// instruction memory, holds each word until retire, and stops in HALT or in a sticky FAULT.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic        clk,
  input  logic        Reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  input  logic        retire,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] HALT  = 3'd3;
  localparam logic [2:0] FAULT = 3'd4;

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT   = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'b10;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [2:0] state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic       target_misaligned;

  assign wait_next         = wait_cnt + 8'd1;
  assign target_misaligned = |redirect_target[1:0];

  // Handshake and status outputs are pure decodes of the state register.
  assign imem_req    = (state == FETCH);
  assign imem_addr   = PC;
  assign instr_valid = (state == ISSUE);
  assign halted      = (state == HALT);
  assign fault       = (state == FAULT);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= IDLE;
      PC          <= RESET_VECTOR;
      instr       <= 32'h0000_0000;
      wait_cnt    <= 8'd0;
      fault_cause <= CAUSE_NONE;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          wait_cnt <= 8'd0;
        end

        FETCH: begin
          if (imem_ready) begin
            instr    <= imem_rdata;
            wait_cnt <= 8'd0;
            state    <= ISSUE;
          end else begin
            wait_cnt <= wait_next;
            if (wait_next == WAIT_LIMIT) begin
              state       <= FAULT;
              fault_cause <= CAUSE_TIMEOUT;
            end
          end
        end

        // Halt outranks a misaligned redirect, which outranks a normal redirect.
        ISSUE: begin
          if (retire) begin
            if (halt) begin
              state <= HALT;
            end else if (redirect && target_misaligned) begin
              state       <= FAULT;
              fault_cause <= CAUSE_MISALIGN;
            end else if (redirect) begin
              PC       <= redirect_target;
              wait_cnt <= 8'd0;
              state    <= FETCH;
            end else begin
              PC       <= PC + 32'd4;
              wait_cnt <= 8'd0;
              state    <= FETCH;
            end
          end
        end

        HALT: begin
          state <= HALT;
        end

        FAULT: begin
          state <= FAULT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
